// File: rtl/dfm_pkg.sv
// Shared types and constants for the frequency-meter control path.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package dfm_pkg;

  // Gate sequencer states; encoding is fixed so debug reads stay stable.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    GATE  = 3'd2,
    CLOSE = 3'd3,
    LATCH = 3'd4
  } gate_state_t;

  // One second at 100 MHz without a signal edge counts as "no signal".
  localparam logic [31:0] TMO_CYC_DEF = 32'd100_000_000;

  // SPI command codes, shared with the SPI command decoder.
  localparam logic [7:0] CONF_WR = 8'h2a;
  localparam logic [7:0] INFO_RD = 8'h3a;
  localparam logic [7:0] DATA_RD = 8'h3b;

endpackage

// File: rtl/gate_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
// Latency: count updates one cycle after en_i; tc_o is combinational from the count.
// Backpressure: none; en_i simply pauses the count.
module gate_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Count enabled cycles from zero; clear wins over enable and the count parks at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/gate_seq.sv
// Measurement gate sequencer: arms on start, gates for gate_time cycles between signal edges, then latches.
// Latency: every output is registered and moves one cycle after the input event that causes it.
// Backpressure: rd_busy_i holds the sequencer in LATCH; stop_i aborts from any busy state.
module gate_seq
  import dfm_pkg::*;
#(
  parameter int          GATE_W  = 32,
  parameter int          TMO_W   = 32,
  parameter logic [31:0] TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              mode_i,
  input  logic [GATE_W-1:0] gate_time_i,
  input  logic              sig_edge_i,
  input  logic              rd_busy_i,
  output logic              gate_o,
  output logic              clr_o,
  output logic              latch_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o
);

  // Compare value is the last allowed count, so a stall lasts exactly TMO_CYC cycles.
  localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TMO_CYC) - TMO_W'(1);

  gate_state_t       state_q;
  logic [GATE_W-1:0] gate_time_q;
  logic [GATE_W-1:0] gate_time_eff;
  logic [GATE_W-1:0] gate_term;
  logic              gate_run;
  logic              tmo_run;
  logic              gate_tc;
  logic              tmo_tc;

  // A zero gate length would never match the counter, so it is promoted to one cycle.
  assign gate_time_eff = (gate_time_i == '0) ? GATE_W'(1) : gate_time_i;
  assign gate_term     = gate_time_q - GATE_W'(1);

  // Counters run only in their own states and sit cleared otherwise, so each starts at zero on entry.
  assign gate_run = (state_q == GATE);
  assign tmo_run  = (state_q == ARM) || (state_q == CLOSE);

  gate_timer #(.W(GATE_W)) u_gate_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (!gate_run),
    .en_i    (gate_run),
    .term_i  (gate_term),
    .tc_o    (gate_tc)
  );

  gate_timer #(.W(TMO_W)) u_tmo_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (!tmo_run),
    .en_i    (tmo_run),
    .term_i  (TMO_TERM),
    .tc_o    (tmo_tc)
  );

  // Sequencer state and all registered outputs; stop_i outranks every other event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      gate_time_q <= GATE_W'(1);
      gate_o      <= 1'b0;
      clr_o       <= 1'b0;
      latch_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      clr_o   <= 1'b0;
      latch_o <= 1'b0;
      if (stop_i) begin
        if (state_q != IDLE) begin
          state_q   <= IDLE;
          gate_o    <= 1'b0;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
          timeout_o <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q     <= ARM;
              gate_time_q <= gate_time_eff;
              busy_o      <= 1'b1;
              clr_o       <= 1'b1;
              done_o      <= 1'b0;
              timeout_o   <= 1'b0;
            end
          end
          ARM: begin
            if (sig_edge_i) begin
              state_q <= GATE;
              gate_o  <= 1'b1;
            end else if (tmo_tc) begin
              state_q   <= LATCH;
              timeout_o <= 1'b1;
            end
          end
          GATE: begin
            if (gate_tc) begin
              state_q <= CLOSE;
            end
          end
          CLOSE: begin
            if (sig_edge_i) begin
              state_q <= LATCH;
              gate_o  <= 1'b0;
            end else if (tmo_tc) begin
              state_q   <= LATCH;
              gate_o    <= 1'b0;
              timeout_o <= 1'b1;
            end
          end
          LATCH: begin
            if (!rd_busy_i) begin
              latch_o <= 1'b1;
              done_o  <= 1'b1;
              if (mode_i) begin
                state_q     <= ARM;
                gate_time_q <= gate_time_eff;
                clr_o       <= 1'b1;
                timeout_o   <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_o  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            gate_o  <= 1'b0;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_seq.sv
// Self-checking bench for gate_seq: scripted and random measurements, event scoreboard.
// Latency: expectations are stated as absolute cycle numbers of each output event.
// Backpressure: rd_busy_i hold-off is part of every measurement schedule.
module tb_gate_seq;

  localparam int T       = 64;
  localparam int K_CLR   = 0;
  localparam int K_LATCH = 1;
  localparam int K_END   = 2;

  typedef struct {
    int kind;
    int cyc;
    int glen;
    int tmo;
    int done;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] gate_time_i = '0;
  logic        sig_edge_i = 1'b0;
  logic        rd_busy_i = 1'b0;
  logic        gate_o, clr_o, latch_o, busy_o, done_o, timeout_o;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   s_cur = 0;
  int   gate_cnt = 0;
  bit   mon_en = 1'b0;
  bit   busy_prev = 1'b0;
  exp_t sb[$];

  gate_seq #(.GATE_W(32), .TMO_W(32), .TMO_CYC(32'd64)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .mode_i      (mode_i),
    .gate_time_i (gate_time_i),
    .sig_edge_i  (sig_edge_i),
    .rd_busy_i   (rd_busy_i),
    .gate_o      (gate_o),
    .clr_o       (clr_o),
    .latch_o     (latch_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic take(input int kind, output exp_t ev, output bit ok);
    ok = 1'b0;
    ev = '{0, 0, 0, 0, 0};
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d, required no event (cycle %0d)", kind, cyc);
    end else begin
      ev = sb.pop_front();
      chk("event_kind", kind, ev.kind);
      ok = (kind == ev.kind);
    end
  endtask

  // Monitor: every output event pops the next expectation; same-cycle order is latch, clr, end.
  always @(negedge clk_i) begin
    exp_t ev;
    bit   ok;
    if (mon_en) begin
      if (latch_o) begin
        take(K_LATCH, ev, ok);
        if (ok) begin
          chk("latch_cycle", cyc, ev.cyc);
          chk("latch_gate_len", gate_cnt, ev.glen);
          chk("latch_timeout", timeout_o, ev.tmo);
          chk("latch_done", done_o, ev.done);
        end
      end
      if (clr_o) begin
        take(K_CLR, ev, ok);
        if (ok) begin
          chk("clr_cycle", cyc, ev.cyc);
          chk("clr_done", done_o, ev.done);
          chk("clr_timeout", timeout_o, 0);
        end
        gate_cnt = 0;
      end
      if (busy_prev && !busy_o) begin
        take(K_END, ev, ok);
        if (ok) begin
          chk("end_cycle", cyc, ev.cyc);
          chk("end_done", done_o, ev.done);
          chk("end_timeout", timeout_o, ev.tmo);
          chk("end_gate", gate_o, 0);
        end
      end
      if (gate_o) gate_cnt++;
    end
    busy_prev = busy_o;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start_i     = 1'b0;
      stop_i      = 1'b0;
      sig_edge_i  = 1'($urandom_range(0, 1));
      rd_busy_i   = 1'($urandom_range(0, 1));
      mode_i      = 1'($urandom_range(0, 1));
      gate_time_i = $urandom;
      tick();
    end
  endtask

  // One measurement described by its timing: d = edge delay after ARM entry, e = edge delay after
  // GATE ends, h = read-busy cycles in LATCH, abort_n = stop offset from ARM entry (0 = none).
  task automatic meas(input int g_in, input int d, input int e, input int h, input bit mode,
                      input int next_g, input int abort_n, input bit first);
    int   s, g, e1, e2, gs, ge, c, l, x, p, p_stop, last, glen;
    int   tmo;
    exp_t ev;
    g = (g_in == 0) ? 1 : g_in;
    e1 = 0; e2 = 0; gs = 0; ge = 0;
    if (first) begin
      s = cyc + 1;
      ev = '{K_CLR, s, 0, 0, 0};
      sb.push_back(ev);
      start_i     = 1'b1;
      stop_i      = 1'b0;
      gate_time_i = g_in;
      sig_edge_i  = 1'($urandom_range(0, 1));
      rd_busy_i   = 1'($urandom_range(0, 1));
      mode_i      = 1'($urandom_range(0, 1));
      tick();
      start_i = 1'b0;
    end else begin
      s = s_cur;
    end
    if (d > T) begin
      l = s + T; glen = 0; tmo = 1;
    end else begin
      e1 = s + d; gs = s + d + 1; ge = s + d + g; c = s + d + g;
      if (e > T) begin
        l = c + T; glen = g + T; tmo = 1;
      end else begin
        e2 = c + e; l = c + e; glen = g + e; tmo = 0;
      end
    end
    x = l + h + 1;
    p_stop = 0;
    if (abort_n > 0) begin
      p_stop = (s + abort_n > x) ? x : s + abort_n;
      last = p_stop;
      ev = '{K_END, p_stop, 0, 0, 0};
      sb.push_back(ev);
    end else begin
      last = x;
      ev = '{K_LATCH, x, glen, mode ? 0 : tmo, 1};
      sb.push_back(ev);
      if (mode) ev = '{K_CLR, x, 0, 0, 1};
      else      ev = '{K_END, x, 0, tmo, 1};
      sb.push_back(ev);
    end
    while (cyc < last) begin
      p = cyc + 1;
      start_i = 1'b0;
      stop_i  = (p == p_stop);
      if (p == e1 || p == e2 || p == p_stop) sig_edge_i = 1'b1;
      else if ((gs != 0 && p >= gs && p <= ge) || p > l) sig_edge_i = 1'($urandom_range(0, 1));
      else sig_edge_i = 1'b0;
      if (p > l && p <= l + h) rd_busy_i = 1'b1;
      else if (p == x)         rd_busy_i = 1'b0;
      else                     rd_busy_i = 1'($urandom_range(0, 1));
      mode_i      = (p == x) ? mode : 1'($urandom_range(0, 1));
      gate_time_i = (p == x) ? next_g : $urandom;
      tick();
    end
    stop_i     = 1'b0;
    sig_edge_i = 1'b0;
    s_cur      = x;
  endtask

  function automatic int rnd_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return T + 1;
    if (r == 1) return T;
    return $urandom_range(1, 6);
  endfunction

  initial begin
    int len, ab, g_cur, g_nxt, lat_cnt;
    bit m;
    repeat (3) tick();
    chk("rst_gate", gate_o, 0);
    chk("rst_clr", clr_o, 0);
    chk("rst_latch", latch_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst_n_i = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;

    meas(10, 3, 4, 0, 1'b0, 0, 0, 1'b1);            // basic single
    idle(2);
    meas(0, 2, 5, 0, 1'b0, 0, 0, 1'b1);             // zero gate time
    idle(2);
    meas(7, T + 1, 1, 0, 1'b0, 0, 0, 1'b1);         // ARM timeout
    idle(2);
    meas(4, 2, 3, 20, 1'b0, 0, 0, 1'b1);            // read hold-off
    idle(1);
    meas(10, 3, 4, 1, 1'b1, 5, 0, 1'b1);            // continuous 10 -> 5 -> 3
    meas(5, 2, 3, 2, 1'b1, 3, 0, 1'b0);
    meas(3, 1, 2, 0, 1'b0, 0, 0, 1'b0);
    idle(2);
    meas(10, 2, 3, 0, 1'b0, 0, 5, 1'b1);            // stop + edge during GATE
    idle(2);
    meas(6, T, T + 1, 0, 1'b0, 0, 0, 1'b1);         // edge on timeout cycle, then CLOSE timeout
    idle(1);
    meas(2, 1, T, 3, 1'b0, 0, 0, 1'b1);             // closing edge on timeout cycle
    idle(1);

    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    tick();
    chk("start_stop_idle_busy", busy_o, 0);

    for (int n = 0; n < 25; n++) begin
      len   = $urandom_range(1, 3);
      g_cur = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        m     = (i < len - 1);
        ab    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 30) : 0;
        g_nxt = $urandom_range(0, 12);
        meas(g_cur, rnd_delay(), rnd_delay(), $urandom_range(0, 4), m, g_nxt, ab, i == 0);
        g_cur = g_nxt;
        if (ab != 0) break;
      end
      idle($urandom_range(1, 3));
    end
    idle(4);
    chk("queue_drained", sb.size(), 0);

    // Asynchronous reset in the middle of a gate.
    mon_en      = 1'b0;
    gate_time_i = 32'd10;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    sig_edge_i = 1'b1;
    tick();
    sig_edge_i = 1'b0;
    tick();
    tick();
    chk("pre_reset_gate", gate_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_reset_gate", gate_o, 0);
    chk("async_reset_busy", busy_o, 0);
    tick();
    rst_n_i = 1'b1;
    lat_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      sig_edge_i = 1'($urandom_range(0, 1));
      tick();
      if (latch_o) lat_cnt++;
    end
    chk("post_reset_latches", lat_cnt, 0);
    chk("post_reset_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
